// File: rtl/fifo_umbrales.sv
// Single-clock 8-deep FIFO with live-programmable low/high occupancy thresholds.
// Feeds one bit of the bank controller's empty_fifos vector and its pause/resume flags.
module fifo_umbrales #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [7:0]            umbral_bajo,
  input  logic [7:0]            umbral_alto,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;
  logic [7:0]            count_ext;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop_ok  = pop && !empty;
  // When full, a simultaneous pop frees rd_ptr's slot, which equals wr_ptr.
  assign push_ok = push && (!full || pop_ok);

  assign count_ext    = 8'(count);
  assign almost_empty = (count_ext <= umbral_bajo);
  assign almost_full  = (count_ext >= umbral_alto);

  // NOTE: storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: non-blocking assignments let mem[rd_ptr] be read before a same-edge overwrite.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if ((push && !push_ok) || (pop && !pop_ok)) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales: directed scenarios then randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_fifo_umbrales;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [7:0]    umbral_bajo;
  logic [7:0]    umbral_alto;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;
  logic          error;

  fifo_umbrales #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .umbral_bajo (umbral_bajo),
    .umbral_alto (umbral_alto),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus sticky error and last popped word.
  logic [DW-1:0] model_q[$];
  logic          m_error;
  logic [DW-1:0] m_dout;
  logic          m_valid;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    int n;
    n = model_q.size();
    check({where, ":count"},        32'(count),        32'(n));
    check({where, ":empty"},        32'(empty),        32'(n == 0));
    check({where, ":full"},         32'(full),         32'(n == DEPTH));
    check({where, ":almost_empty"}, 32'(almost_empty), 32'(n <= int'(umbral_bajo)));
    check({where, ":almost_full"},  32'(almost_full),  32'(n >= int'(umbral_alto)));
    check({where, ":error"},        32'(error),        32'(m_error));
    check({where, ":valid_out"},    32'(valid_out),    32'(m_valid));
    check({where, ":data_out"},     32'(data_out),     32'(m_dout));
  endtask

  task automatic model_reset();
    model_q.delete();
    m_error = 1'b0;
    m_dout  = '0;
    m_valid = 1'b0;
  endtask

  // Called at a negedge; applies one cycle of traffic and checks after the next negedge.
  task automatic step(input string where, input logic p, input logic [DW-1:0] d, input logic r);
    bit can_pop, can_push;
    push    = p;
    data_in = d;
    pop     = r;
    can_pop  = r && (model_q.size() > 0);
    can_push = p && (model_q.size() < DEPTH || can_pop);
    @(posedge clk);
    if (can_pop) begin
      m_dout  = model_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (can_push) model_q.push_back(d);
    if ((p && !can_push) || (r && !can_pop)) m_error = 1'b1;
    @(negedge clk);
    check_all(where);
  endtask

  // Asserts reset between edges, checks the immediate effect, releases at the next negedge.
  task automatic do_reset(input string where);
    push = 1'b0;
    pop  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    data_in     = '0;
    umbral_bajo = 8'd2;
    umbral_alto = 8'd6;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    step("idle", 1'b0, '0, 1'b0);

    // Fill, then overflow push.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0);
    step("overflow", 1'b1, 6'h3F, 1'b0);

    // Drain in order, then underflow pop.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("underflow", 1'b0, '0, 1'b1);

    // Pointer wrap with a clean error flag.
    do_reset("rst_wrap");
    for (int i = 0; i < 5; i++) step("wrap_push5", 1'b1, DW'(i + 1), 1'b0);
    for (int i = 0; i < 5; i++) step("wrap_pop5", 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step("wrap_push6", 1'b1, DW'(8'h10 + i), 1'b0);
    for (int i = 0; i < 6; i++) step("wrap_pop6", 1'b0, '0, 1'b1);

    // Simultaneous push+pop when full, then when empty.
    for (int i = 0; i < DEPTH; i++) step("sim_fill", 1'b1, DW'(8'h30 + i), 1'b0);
    step("sim_full", 1'b1, 6'h3E, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("sim_drain", 1'b0, '0, 1'b1);
    step("sim_empty", 1'b1, 6'h21, 1'b1);
    step("sim_after", 1'b0, '0, 1'b1);

    // Reset mid-operation, then reuse.
    for (int i = 0; i < 4; i++) step("mid_fill", 1'b1, DW'(8'h05 + i), 1'b0);
    do_reset("rst_mid");
    step("post_push", 1'b1, 6'h2A, 1'b0);
    step("post_pop", 1'b0, '0, 1'b1);
    umbral_alto = 8'd0;
    #1;
    check_all("alto_zero");

    // Randomized traffic with occasional live threshold changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_bajo = 8'($urandom_range(0, 10));
        umbral_alto = 8'($urandom_range(0, 10));
        #1;
        check_all("thr_change");
      end
      if (i == 200) do_reset("rst_rand");
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
